encoder16_serializer: RTL
=========================

// Module: encoder16_serializer
// PURPOSE
//  16-to-4 encoding counterpart of the 4-to-16 one-hot decoder. Accepts a 16-bit request
//  vector, queues every set bit in a pending register, and emits each bit's 4-bit index
//  one at a time on a valid/ready output port. Sits between request sources (e.g. decoded
//  select lines) and a consumer that takes one binary index per transfer.
// PARAMETERS
//  ROUND_ROBIN  0  0 = fixed priority, lowest index first; 1 = rotating priority from ptr
// PORTS
//  clk          in   1   rising-edge clock, single clock domain
//  reset        in   1   synchronous reset, active-high
//  enable       in   1   1 = block operates; 0 = freeze (no load, no issue)
//  load         in   1   strobe: merge encoder_in into pending this cycle
//  encoder_in   in   16  request vector, any number of bits set
//  ready_in     in   1   consumer accepts binary_out when valid_out & ready_in
//  binary_out   out  4   encoded index of the issued request
//  valid_out    out  1   binary_out holds a valid index
//  busy         out  1   valid_out | (|pending)
//  overrun      out  1   sticky: a loaded bit was already pending
// BEHAVIOUR
//  Reset (sync, active-high, overrides all): pending=0, binary_out=0, valid_out=0,
//   overrun=0, ptr=0. Reset mid-operation discards all pending and in-flight requests.
//  Issue condition: issue = enable & (|pending) & (~valid_out | ready_in).
//   On issue, idx = selected bit of pending; next cycle binary_out=idx, valid_out=1,
//   and pop_mask = (1<<idx). Otherwise pop_mask=0.
//  Output retire: valid_out & ready_in & ~issue -> valid_out<=0; binary_out holds last value.
//  Backpressure: valid_out=1 & ready_in=0 -> binary_out and valid_out stable; no issue.
//  Back-to-back: valid_out & ready_in & |pending -> next index issued the same cycle,
//   so valid_out stays 1 (full throughput, 1 index/cycle).
//  Pending update: pending <= (pending & ~pop_mask) | ((enable & load) ? encoder_in : 0).
//   The bit being popped may be re-requested in the same cycle; it is re-queued with no overrun.
//  Overrun: set when enable & load & |(encoder_in & pending & ~pop_mask); cleared by reset only.
//  Latency: pending is the only issue source. A load in cycle N updates pending at
//   edge N+1; the earliest valid_out=1 for it is after edge N+2 (2 cycles).
//  Selection: ROUND_ROBIN=0 picks the lowest set index.
//   ROUND_ROBIN=1 picks the first set index scanning ptr, ptr+1 .. 15, 0 .. ptr-1 (mod 16).
//   On each issue, ptr <= idx+1 with 4-bit wrap (15 -> 0). ptr does not change without issue.
//  enable=0: pending, ptr, binary_out and valid_out all hold; load is ignored and not
//   counted toward overrun. ready_in is ignored: an output held while enable=0 is not retired.
//  busy is combinational from the registers; binary_out is registered; no comb path in->out.
// TESTING
//  T1 Reset: drive reset 1 cycle mid-stream with pending=16'hFFFF
//     -> valid_out=0, busy=0, overrun=0, binary_out=0 the next cycle.
//  T2 Single load: load 16'h0400 at N with ready_in=1
//     -> valid_out=1, binary_out=4'hA after edge N+2; valid_out=0 the following cycle.
//  T3 Fixed priority with backpressure: load 16'h8011, ready_in=0 for 3 cycles, then 1
//     -> 4'h0 held stable for 3 cycles, then 4'h4, then 4'hF on consecutive cycles.
//  T4 Round-robin (ROUND_ROBIN=1): load 16'h0005, pop 0, then load 16'h0001 again
//     -> order is 0, 2, 0 (ptr=1 skips the re-loaded bit 0 until bit 2 is done).
//  T5 Overrun: load 16'h0003, then load 16'h0002 while bit 1 is still pending
//     -> overrun=1 and stays 1; index 1 is emitted once.
//     Re-loading exactly the popped bit -> overrun stays 0 and that bit is emitted again.
//  T6 Freeze: enable=0 for 4 cycles with valid_out=1, ready_in=1 and load=1 of 16'h00F0
//     -> all outputs stable; pending unchanged; on enable=1 the queue resumes.

Source files
------------

// File: rtl/encoder16_serializer.sv
// Queues set bits of a 16-bit request vector and emits their 4-bit indices one per transfer.
// Fixed (lowest-first) or rotating priority; registered output on a valid/ready port.
module encoder16_serializer #(
   parameter int ROUND_ROBIN = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        load,
   input  logic [15:0] encoder_in,
   input  logic        ready_in,
   output logic [3:0]  binary_out,
   output logic        valid_out,
   output logic        busy,
   output logic        overrun
);

   logic [15:0] pending;
   logic [15:0] pop_mask;
   logic [15:0] load_mask;
   logic [3:0]  ptr;
   logic [3:0]  sel_idx;
   logic [3:0]  cand;
   logic        found;
   logic        issue;

   // Scan from ptr (rotating) or from 0 (fixed); first pending bit wins.
   always_comb begin
      sel_idx = '0;
      cand    = '0;
      found   = 1'b0;
      for (int i = 0; i < 16; i++) begin
         cand = (ROUND_ROBIN != 0) ? ptr + 4'(i) : 4'(i);
         if (!found && pending[cand]) begin
            sel_idx = cand;
            found   = 1'b1;
         end
      end
   end

   assign issue     = enable & (|pending) & (~valid_out | ready_in);
   assign pop_mask  = issue ? (16'h0001 << sel_idx) : 16'h0000;
   assign load_mask = (enable & load) ? encoder_in : 16'h0000;
   assign busy      = valid_out | (|pending);

   always_ff @(posedge clk) begin
      if (reset) begin
         pending    <= '0;
         binary_out <= '0;
         valid_out  <= 1'b0;
         overrun    <= 1'b0;
         ptr        <= '0;
      end else begin
         // A bit popped this cycle may be re-requested without counting as overrun.
         pending <= (pending & ~pop_mask) | load_mask;
         if (|(load_mask & pending & ~pop_mask))
            overrun <= 1'b1;
         if (issue) begin
            binary_out <= sel_idx;
            valid_out  <= 1'b1;
            ptr        <= sel_idx + 4'd1;
         end else if (enable & valid_out & ready_in) begin
            valid_out <= 1'b0;
         end
      end
   end

endmodule
